// File: rtl/hist_equalizer.sv
// Histogram equaliser: builds a 256-entry mapping LUT from the streamed cumulative histogram,
// swaps it in at frame start and remaps grey pixels. Optional feature macro: HIST_EQ_BYPASS_EN.
module hist_equalizer #(
    parameter int TOTAL_LOG2 = 10,
    parameter int CUM_W      = 20
) (
    input  logic             iPclk,
    input  logic             iRST,
    input  logic             Fval,
    input  logic             Dval,
    input  logic [11:0]      Grey,
    input  logic             iCum_Valid,
    input  logic [7:0]       iCum_Bin,
    input  logic [CUM_W-1:0] iCum,
`ifdef HIST_EQ_BYPASS_EN
    input  logic             iBypass,
`endif
    output logic             oDval,
    output logic [11:0]      oGrey_Eq,
    output logic [15:0]      oWr1_Data,
    output logic [15:0]      oWr2_Data,
    output logic             oLut_Valid,
    output logic             oLoad_Err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam logic [CUM_W+7:0] ENTRY_MAX = (CUM_W+8)'(255);

    state_t           state_q, state_d;
    logic [7:0]       exp_bin_q, exp_bin_d;
    logic             fval_q, fval_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             active_q, active_d;
    logic             lut_valid_q, lut_valid_d;
    logic             load_err_q, load_err_d;
    logic             dval1_q, dval1_d, dval2_q, dval2_d, dval_o_q, dval_o_d;
    logic [11:0]      grey1_q, grey1_d, grey2_q, grey2_d, grey_eq_q, grey_eq_d;
    logic             byp1_q, byp1_d, byp2_q, byp2_d;
    logic             use_lut2_q, use_lut2_d;
    logic [7:0]       lut_rd_q, lut_rd_d;
    logic [15:0]      wr1_q, wr1_d, wr2_q, wr2_d;
    logic [7:0]       lut_mem [0:511];

    logic             fval_rise_s, bin_match_s, last_bin_s;
    logic             wr_en_s, abort_s, swap_s, byp_s;
    logic [CUM_W+7:0] prod_s, scaled_s;
    logic [7:0]       entry_s;

`ifdef HIST_EQ_BYPASS_EN
    assign byp_s = iBypass;
`else
    assign byp_s = 1'b0;
`endif

    assign fval_rise_s = Fval & ~fval_q;
    assign bin_match_s = iCum_Valid & (iCum_Bin == exp_bin_q);
    assign last_bin_s  = bin_match_s & (exp_bin_q == 8'd255);

    // Truncating scale of the cumulative count to 0..255 with saturation
    always_comb begin
        prod_s   = {8'd0, iCum} * {{CUM_W{1'b0}}, 8'd255};
        scaled_s = prod_s >> TOTAL_LOG2;
        if (scaled_s > ENTRY_MAX) begin
            entry_s = 8'hFF;
        end else begin
            entry_s = scaled_s[7:0];
        end
    end

    // Load FSM next state; a bin-255 word beats a coincident Fval rise
    always_comb begin
        state_d   = state_q;
        exp_bin_d = exp_bin_q;
        case (state_q)
            ST_IDLE: begin
                if (iCum_Valid && (iCum_Bin == 8'd0)) begin
                    state_d   = ST_LOAD;
                    exp_bin_d = 8'd1;
                end else begin
                    exp_bin_d = 8'd0;
                end
            end
            ST_LOAD: begin
                if (last_bin_s) begin
                    state_d   = ST_READY;
                    exp_bin_d = 8'd0;
                end else if (fval_rise_s || iCum_Valid && !bin_match_s) begin
                    state_d   = ST_IDLE;
                    exp_bin_d = 8'd0;
                end else if (bin_match_s) begin
                    exp_bin_d = exp_bin_q + 8'd1;
                end else begin
                    exp_bin_d = exp_bin_q;
                end
            end
            ST_READY: begin
                if (fval_rise_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READY;
                end
                exp_bin_d = 8'd0;
            end
            default: begin
                state_d   = ST_IDLE;
                exp_bin_d = 8'd0;
            end
        endcase
    end

    // Load FSM outputs
    always_comb begin
        wr_en_s = 1'b0;
        abort_s = 1'b0;
        swap_s  = 1'b0;
        case (state_q)
            ST_IDLE:  wr_en_s = iCum_Valid & (iCum_Bin == 8'd0);
            ST_LOAD: begin
                wr_en_s = last_bin_s | (bin_match_s & ~fval_rise_s);
                abort_s = ~last_bin_s & (fval_rise_s | (iCum_Valid & ~bin_match_s));
            end
            ST_READY: swap_s = fval_rise_s;
            default:  wr_en_s = 1'b0;
        endcase
    end

    // Bank control, write staging and the pixel pipeline
    always_comb begin
        fval_d      = Fval;
        wr_en_d     = wr_en_s;
        wr_addr_d   = iCum_Bin;
        wr_data_d   = entry_s;
        active_d    = swap_s ? ~active_q : active_q;
        lut_valid_d = swap_s | lut_valid_q;
        if (swap_s) begin
            load_err_d = 1'b0;
        end else begin
            load_err_d = load_err_q | abort_s;
        end
        dval1_d    = Dval;
        grey1_d    = Grey;
        byp1_d     = byp_s;
        dval2_d    = dval1_q;
        grey2_d    = grey1_q;
        byp2_d     = byp1_q;
        // Valid flag is sampled with the read so in-flight pixels keep their bank's meaning
        use_lut2_d = lut_valid_q;
        lut_rd_d   = lut_mem[{active_q, grey1_q[11:4]}];
        dval_o_d   = dval2_q;
        if (!dval2_q) begin
            grey_eq_d = 12'd0;
        end else if (use_lut2_q && !byp2_q) begin
            grey_eq_d = {lut_rd_q, lut_rd_q[7:4]};
        end else begin
            grey_eq_d = grey2_q;
        end
        wr1_d = {1'b0, grey_eq_d[11:7], grey_eq_d[11:2]};
        wr2_d = {1'b0, grey_eq_d[6:2], grey_eq_d[11:2]};
    end

    // State and pipeline registers
    always_ff @(posedge iPclk or posedge iRST) begin
        if (iRST) begin
            state_q     <= ST_IDLE;
            exp_bin_q   <= 8'd0;
            fval_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 8'd0;
            wr_data_q   <= 8'd0;
            active_q    <= 1'b0;
            lut_valid_q <= 1'b0;
            load_err_q  <= 1'b0;
            dval1_q     <= 1'b0;
            grey1_q     <= 12'd0;
            byp1_q      <= 1'b0;
            dval2_q     <= 1'b0;
            grey2_q     <= 12'd0;
            byp2_q      <= 1'b0;
            use_lut2_q  <= 1'b0;
            lut_rd_q    <= 8'd0;
            dval_o_q    <= 1'b0;
            grey_eq_q   <= 12'd0;
            wr1_q       <= 16'd0;
            wr2_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            exp_bin_q   <= exp_bin_d;
            fval_q      <= fval_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            active_q    <= active_d;
            lut_valid_q <= lut_valid_d;
            load_err_q  <= load_err_d;
            dval1_q     <= dval1_d;
            grey1_q     <= grey1_d;
            byp1_q      <= byp1_d;
            dval2_q     <= dval2_d;
            grey2_q     <= grey2_d;
            byp2_q      <= byp2_d;
            use_lut2_q  <= use_lut2_d;
            lut_rd_q    <= lut_rd_d;
            dval_o_q    <= dval_o_d;
            grey_eq_q   <= grey_eq_d;
            wr1_q       <= wr1_d;
            wr2_q       <= wr2_d;
        end
    end

    // Shadow-bank write; the active bank is never the target
    always_ff @(posedge iPclk) begin
        if (wr_en_q) begin
            lut_mem[{~active_q, wr_addr_q}] <= wr_data_q;
        end
    end

    assign oDval      = dval_o_q;
    assign oGrey_Eq   = grey_eq_q;
    assign oWr1_Data  = wr1_q;
    assign oWr2_Data  = wr2_q;
    assign oLut_Valid = lut_valid_q;
    assign oLoad_Err  = load_err_q;

endmodule

// File: tb/tb_hist_equalizer.sv
// Scoreboard bench for hist_equalizer: directed loads, frame swaps, error and reset cases.
module tb_hist_equalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        Fval, Dval, iCum_Valid;
    logic [11:0] Grey;
    logic [7:0]  iCum_Bin;
    logic [19:0] iCum;
    logic        oDval, oLut_Valid, oLoad_Err;
    logic [11:0] oGrey_Eq;
    logic [15:0] oWr1_Data, oWr2_Data;
`ifdef HIST_EQ_BYPASS_EN
    logic        byp;
`endif

    always #5 clk = ~clk;

    hist_equalizer #(.TOTAL_LOG2(10), .CUM_W(20)) dut (
        .iPclk(clk), .iRST(rst), .Fval(Fval), .Dval(Dval), .Grey(Grey),
        .iCum_Valid(iCum_Valid), .iCum_Bin(iCum_Bin), .iCum(iCum),
`ifdef HIST_EQ_BYPASS_EN
        .iBypass(byp),
`endif
        .oDval(oDval), .oGrey_Eq(oGrey_Eq), .oWr1_Data(oWr1_Data), .oWr2_Data(oWr2_Data),
        .oLut_Valid(oLut_Valid), .oLoad_Err(oLoad_Err)
    );

    typedef struct {
        logic [11:0] g;
        logic [15:0] w1;
        logic [15:0] w2;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] wr1_of(input logic [11:0] g);
        return {1'b0, g[11:7], g[11:2]};
    endfunction

    function automatic logic [15:0] wr2_of(input logic [11:0] g);
        return {1'b0, g[6:2], g[11:2]};
    endfunction

    // mode 0: 4*(bin+1) (total 1024); mode 1: 2*(bin+1) with saturating top bins
    function automatic logic [19:0] cum_of(input int mode, input int b);
        if (mode == 0) return 20'(4 * (b + 1));
        if (b == 255) return 20'hFFFFF;
        if (b == 254) return 20'hFFC00;
        return 20'(2 * (b + 1));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pix_full(input logic [11:0] g, input logic [11:0] eg,
                            input logic [15:0] w1, input logic [15:0] w2);
        Dval = 1'b1;
        Grey = g;
        sb.push_back('{eg, w1, w2, cyc + 3});
        step();
        Dval = 1'b0;
    endtask

    task automatic pix(input logic [11:0] g, input logic [11:0] eg);
        pix_full(g, eg, wr1_of(eg), wr2_of(eg));
    endtask

    task automatic cum_word(input int b, input logic [19:0] c);
        iCum_Valid = 1'b1;
        iCum_Bin   = 8'(b);
        iCum       = c;
        step();
        iCum_Valid = 1'b0;
    endtask

    task automatic load(input int mode, input int lo, input int hi);
        for (int b = lo; b <= hi; b++) cum_word(b, cum_of(mode, b));
    endtask

    // Monitor: pops an expectation for every output pixel, otherwise outputs must be zero
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (oDval) begin
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL pix_unexpected: got grey %h at cycle %0d, expected no pixel", oGrey_Eq, cyc);
                end else begin
                    e = sb.pop_front();
                    if (oGrey_Eq !== e.g || oWr1_Data !== e.w1 || oWr2_Data !== e.w2 || cyc != e.due) begin
                        n_fail++;
                        $display("FAIL pix: got grey %h wr1 %h wr2 %h cycle %0d, expected grey %h wr1 %h wr2 %h cycle %0d",
                                 oGrey_Eq, oWr1_Data, oWr2_Data, cyc, e.g, e.w1, e.w2, e.due);
                    end
                end
            end else if ({oGrey_Eq, oWr1_Data, oWr2_Data} !== 44'd0) begin
                n_fail++;
                $display("FAIL idle_zero: got grey %h wr1 %h wr2 %h, expected 0", oGrey_Eq, oWr1_Data, oWr2_Data);
            end
        end
    end

    initial begin
        rst = 1'b1; Fval = 1'b0; Dval = 1'b0; Grey = 12'd0;
        iCum_Valid = 1'b0; iCum_Bin = 8'd0; iCum = 20'd0;
`ifdef HIST_EQ_BYPASS_EN
        byp = 1'b0;
`endif
        repeat (3) step();
        chk("rst_dval", 32'(oDval), 32'd0);
        chk("rst_grey", 32'(oGrey_Eq), 32'd0);
        chk("rst_lut_valid", 32'(oLut_Valid), 32'd0);
        chk("rst_load_err", 32'(oLoad_Err), 32'd0);
        rst = 1'b0;
        step();

        // No LUT loaded: identity pass-through
        Fval = 1'b1;
        pix_full(12'hABC, 12'hABC, 16'h56AF, 16'h3EAF);
        pix(12'h123, 12'h123);
        Fval = 1'b0;
        step();
        chk("nolut_valid", 32'(oLut_Valid), 32'd0);

        // Linear LUT, swapped in at the next frame start
        load(0, 0, 255);
        step(); step();
        Fval = 1'b1;
        pix(12'h7F0, 12'h7F7);
        pix(12'h40A, 12'h404);
        pix(12'hC80, 12'hC8C);
        pix(12'hFF0, 12'hFFF);
        chk("lin_valid", 32'(oLut_Valid), 32'd1);
        chk("lin_err", 32'(oLoad_Err), 32'd0);
        Fval = 1'b0;
        step();

        // Saturating LUT whose bin-255 word coincides with an Fval rise: swap is deferred
        load(1, 0, 254);
        Fval = 1'b1;
        cum_word(255, cum_of(1, 255));
        pix(12'h7F0, 12'h7F7);
        Fval = 1'b0;
        step(); step();
        Fval = 1'b1;
        pix(12'h7F0, 12'h3F3);
        pix(12'hFE0, 12'hFFF);
        pix(12'hFF0, 12'hFFF);
        pix(12'h40A, 12'h202);
        Fval = 1'b0;
        step();

        // Out-of-order load aborts; no swap at the next frame
        cum_word(0, cum_of(0, 0));
        cum_word(1, cum_of(0, 1));
        cum_word(3, cum_of(0, 3));
        chk("ooo_err", 32'(oLoad_Err), 32'd1);
        Fval = 1'b1;
        pix(12'h7F0, 12'h3F3);
        chk("ooo_valid", 32'(oLut_Valid), 32'd1);
        chk("ooo_err_hold", 32'(oLoad_Err), 32'd1);
        Fval = 1'b0;
        step();
        load(0, 0, 255);
        step();
        Fval = 1'b1;
        pix(12'h7F0, 12'h7F7);
        pix(12'hC80, 12'hC8C);
        chk("reload_err_clr", 32'(oLoad_Err), 32'd0);
        Fval = 1'b0;
        step();

        // Fval rises at bin 100 of a load
        load(1, 0, 99);
        Fval = 1'b1;
        cum_word(100, cum_of(1, 100));
        chk("fval_abort_err", 32'(oLoad_Err), 32'd1);
        pix(12'h7F0, 12'h7F7);
        pix(12'h40A, 12'h404);
        repeat (4) step();
        Fval = 1'b0;
        step();

        // Reset mid-load with a pixel in flight
        load(1, 0, 50);
        Fval = 1'b1;
        Dval = 1'b1;
        Grey = 12'h7F0;
        step();
        Dval = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mrst_dval", 32'(oDval), 32'd0);
        chk("mrst_grey", 32'(oGrey_Eq), 32'd0);
        chk("mrst_wr1", 32'(oWr1_Data), 32'd0);
        chk("mrst_lut_valid", 32'(oLut_Valid), 32'd0);
        chk("mrst_err", 32'(oLoad_Err), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        step();
        pix(12'h123, 12'h123);
        pix(12'h7F0, 12'h7F0);
        chk("post_rst_valid", 32'(oLut_Valid), 32'd0);

`ifdef HIST_EQ_BYPASS_EN
        Fval = 1'b0;
        step();
        load(0, 0, 255);
        step();
        Fval = 1'b1;
        byp = 1'b1;
        pix(12'h123, 12'h123);
        pix(12'h7F0, 12'h7F0);
        byp = 1'b0;
        pix(12'h7F0, 12'h7F7);
        chk("byp_valid", 32'(oLut_Valid), 32'd1);
`endif

        repeat (6) step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
